jk_bank_ctrl: RTL and testbench

Shared-access controller for a bank of JK flip-flops. Up to NREQ requesters each post a command (HOLD/RESET/SET/TOGGLE) targeting one bit of a WIDTH-bit JK bank. A round-robin arbiter grants one requester at a time. The FSM then drives that bit's J/K inputs for exactly one clock. The block owns the bank and exports its state as Q.

---
 rtl/jk_bank_ctrl_pkg.sv | 26 ++
 rtl/jk_rr_arb.sv | 42 ++++
 rtl/jk_bank_ctrl.sv | 116 +++++++++++
 tb/tb_jk_bank_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_ctrl_pkg.sv
// Shared types and the JK next-state function for the jk_bank_ctrl block.
package jk_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_APPLY
  } state_e;

  // Standard JK truth table for a single flop.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_rr_arb.sv
// Round-robin arbiter for jk_bank_ctrl; with JK_BANK_CTRL_PRIO_EN requester 0
// overrides the rotation and the rest rotate among themselves.
module jk_rr_arb #(
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);

  always_comb begin
    int cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
`ifdef JK_BANK_CTRL_PRIO_EN
      // Requester 0 is handled by the override below, never by the rotation.
      if (!any_o && req_i[cand] && cand != 0) begin
`else
      if (!any_o && req_i[cand]) begin
`endif
        any_o     = 1'b1;
        gnt_idx_o = IDW'(cand);
      end
    end
`ifdef JK_BANK_CTRL_PRIO_EN
    if (req_i[0]) begin
      any_o     = 1'b1;
      gnt_idx_o = '0;
    end
`endif
    if (any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Arbitrated command controller owning a WIDTH-bit JK flop bank.
// Optional macro JK_BANK_CTRL_PRIO_EN gives requester 0 absolute priority.
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  WIDTH = 8,
  parameter int  IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [2*NREQ-1:0]    REQ_CMD,
  input  logic [IDXW*NREQ-1:0] REQ_IDX,
  output logic [NREQ-1:0]      REQ_READY,
  output logic [WIDTH-1:0]     Q,
  output logic                 GNT_VALID,
  output logic [IDW-1:0]       GNT_ID,
  output logic                 ERR,
  output logic                 BUSY
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  jk_cmd_e          cmd_q, cmd_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] j_vec, k_vec;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             apply;

  jk_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i     (REQ_VALID),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign apply = (state_q == ST_APPLY);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    REQ_READY = '0;
    GNT_VALID = 1'b0;
    ERR       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // READY is forced low while reset is held, even with requests pending.
        REQ_READY = RST_N ? gnt : '0;
        if (gnt_any) begin
          state_d = ST_APPLY;
          cmd_d   = jk_cmd_e'(REQ_CMD[2*int'(gnt_idx) +: 2]);
          idx_d   = REQ_IDX[IDXW*int'(gnt_idx) +: IDXW];
          id_d    = gnt_idx;
          ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
`ifdef JK_BANK_CTRL_PRIO_EN
          if (gnt_idx == '0) ptr_d = ptr_q;
`endif
        end
      end
      ST_APPLY: begin
        GNT_VALID = 1'b1;
        ERR       = (int'(idx_q) >= WIDTH);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the addressed bit sees J/K from the command; an out-of-range index
  // matches no bit, so the whole bank holds.
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      j_vec[b] = apply && (int'(idx_q) == b) && cmd_q[1];
      k_vec[b] = apply && (int'(idx_q) == b) && cmd_q[0];
      q_d[b]   = jk_next(q_q[b], j_vec[b], k_vec[b]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cmd_q   <= JK_HOLD;
      idx_q   <= '0;
      q_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
    end
  end

  assign Q      = q_q;
  assign GNT_ID = id_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed steps plus random traffic
// against a queue-based behavioural model.
module tb_jk_bank_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IW   = 3;
`ifdef JK_BANK_CTRL_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                 CLK, RST_N;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_cmd;
  logic [IW*NREQ-1:0]   req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [W-1:0]         q;
  logic                 gnt_valid, err, busy;
  logic [1:0]           gnt_id;

  logic [NREQ-1:0]      v6;
  logic [2*NREQ-1:0]    cmd6;
  logic [IW*NREQ-1:0]   idx6;
  logic [NREQ-1:0]      ready6;
  logic [5:0]           q6;
  logic                 gv6, err6, busy6;
  logic [1:0]           gid6;

  int checks = 0;
  int errors = 0;

  bit         m_apply;
  int         m_ptr, m_id, m_idx;
  logic [1:0] m_cmd;
  logic [W-1:0] m_q;
  int         gnt_log[$];

  jk_bank_ctrl #(.NREQ(NREQ), .WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(req_valid), .REQ_CMD(req_cmd),
    .REQ_IDX(req_idx), .REQ_READY(req_ready), .Q(q), .GNT_VALID(gnt_valid),
    .GNT_ID(gnt_id), .ERR(err), .BUSY(busy)
  );

  jk_bank_ctrl #(.NREQ(NREQ), .WIDTH(6)) dut6 (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(v6), .REQ_CMD(cmd6),
    .REQ_IDX(idx6), .REQ_READY(ready6), .Q(q6), .GNT_VALID(gv6),
    .GNT_ID(gid6), .ERR(err6), .BUSY(busy6)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_apply = 1'b0;
    m_ptr   = 0;
    m_id    = 0;
    m_idx   = 0;
    m_cmd   = 2'b00;
    m_q     = '0;
  endtask

  // Build the search order from the pointer, then take the first valid entry.
  function automatic int model_winner(input logic [NREQ-1:0] v);
    int order[$];
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
    foreach (order[i])
      if (v[order[i]] && !(PRIO && order[i] == 0)) return order[i];
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int w;
    logic [NREQ-1:0] er;
    @(negedge CLK);
    w  = m_apply ? -1 : model_winner(req_valid);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check("ready", req_ready, er);
    check("gnt_valid", gnt_valid, m_apply);
    if (m_apply) check("gnt_id", gnt_id, m_id);
    check("err", err, m_apply && (m_idx >= W));
    check("busy", busy, m_apply);
    check("q", q, m_q);
    if (gnt_valid) gnt_log.push_back(int'(gnt_id));
    @(posedge CLK);
    if (m_apply) begin
      if (m_idx < W) begin
        case (m_cmd)
          2'b01:   m_q[m_idx] = 1'b0;
          2'b10:   m_q[m_idx] = 1'b1;
          2'b11:   m_q[m_idx] = ~m_q[m_idx];
          default: ;
        endcase
      end
      m_apply = 1'b0;
    end else if (w >= 0) begin
      m_apply = 1'b1;
      m_cmd   = req_cmd[2*w +: 2];
      m_idx   = int'(req_idx[IW*w +: IW]);
      m_id    = w;
      if (!(PRIO && w == 0)) m_ptr = (w + 1) % NREQ;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    model_reset();
    repeat (n) begin
      req_valid = NREQ'($urandom);
      req_cmd   = $urandom;
      req_idx   = $urandom;
      v6        = NREQ'($urandom);
      @(negedge CLK);
      check("rst_q", q, 0);
      check("rst_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_gnt_valid", gnt_valid, 0);
      check("rst_gnt_id", gnt_id, 0);
      check("rst_err", err, 0);
      check("rst_q6", q6, 0);
      check("rst_ready6", ready6, 0);
      @(posedge CLK);
      #1;
    end
    req_valid = '0;
    v6        = '0;
    RST_N     = 1'b1;
  endtask

  task automatic send(input int r, input logic [1:0] c, input int idx);
    req_valid[r]         = 1'b1;
    req_cmd[2*r +: 2]    = c;
    req_idx[IW*r +: IW]  = IW'(idx);
    cycle();
    req_valid[r] = 1'b0;
    req_cmd      = $urandom;
    req_idx      = $urandom;
    cycle();
    cycle();
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    RST_N = 1'b0;
    req_valid = '0; req_cmd = '0; req_idx = '0;
    v6 = '0; cmd6 = '0; idx6 = '0;
    model_reset();

    do_reset(3);
    repeat (3) cycle();

    send(0, 2'b10, 3);
    check("set_bit3", q, 8'h08);
    send(0, 2'b11, 3);
    check("toggle1", q, 8'h00);
    send(0, 2'b11, 3);
    check("toggle2", q, 8'h08);
    send(0, 2'b01, 3);
    check("reset_bit3", q, 8'h00);
    gnt_log.delete();
    send(0, 2'b00, 3);
    check("hold_q", q, 8'h00);
    check("hold_pulses", gnt_log.size(), 1);

`ifndef JK_BANK_CTRL_PRIO_EN
    do_reset(2);
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = 1'b1;
      req_cmd[2*i +: 2]   = 2'b11;
      req_idx[IW*i +: IW] = IW'(i);
    end
    repeat (8) cycle();
    check("rr_q", q, 8'h0F);
    repeat (2) cycle();
    check("rr_count", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      check("rr_order", gnt_log[i], exp_order[i]);
    req_valid = '0;
    cycle();
`else
    do_reset(1);
    gnt_log.delete();
    req_valid[0] = 1'b1; req_cmd[1:0] = 2'b11; req_idx[2:0] = 3'd0;
    req_valid[2] = 1'b1; req_cmd[5:4] = 2'b11; req_idx[8:6] = 3'd2;
    repeat (8) cycle();
    check("prio_count", gnt_log.size(), 4);
    foreach (gnt_log[i]) check("prio_winner", gnt_log[i], 0);
    req_valid[0] = 1'b0;
    gnt_log.delete();
    repeat (2) cycle();
    check("prio_hand_off_count", gnt_log.size(), 1);
    if (gnt_log.size() > 0) check("prio_hand_off", gnt_log[0], 2);
    req_valid = '0;
    cycle();
`endif

    repeat (400) begin
      req_valid = NREQ'($urandom);
      req_cmd   = $urandom;
      req_idx   = $urandom;
      cycle();
    end
    req_valid = '0;
    repeat (2) cycle();

    send(1, 2'b10, 5);
    req_valid[1]     = 1'b1;
    req_cmd[3:2]     = 2'b10;
    req_idx[5:3]     = 3'd2;
    cycle();
    req_valid = '0;
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_gnt_valid", gnt_valid, 0);
    model_reset();
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (4) cycle();
    check("no_late_write", q, 0);

    v6[0] = 1'b1; cmd6[1:0] = 2'b10; idx6[2:0] = 3'd1;
    @(negedge CLK);
    check("w6_ready", ready6, 4'b0001);
    @(posedge CLK); #1 v6 = '0;
    @(negedge CLK);
    check("w6_gv", gv6, 1);
    check("w6_err_ok", err6, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("w6_q_set", q6, 6'h02);
    @(posedge CLK); #1;
    v6[0] = 1'b1; cmd6[1:0] = 2'b10; idx6[2:0] = 3'd7;
    @(negedge CLK);
    check("w6_oor_ready", ready6, 4'b0001);
    @(posedge CLK); #1 v6 = '0;
    @(negedge CLK);
    check("w6_oor_err", err6, 1);
    check("w6_oor_gv", gv6, 1);
    check("w6_oor_q", q6, 6'h02);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("w6_err_clear", err6, 0);
    check("w6_q_after", q6, 6'h02);
    check("w6_gv_clear", gv6, 0);
    @(posedge CLK); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
